// File: rtl/nibble_serial_add_ctrl_pkg.sv
// rtl/nibble_serial_add_ctrl_pkg.sv - shared constants for the nibble-serial adder
package nibble_serial_add_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef logic [NIB_W-1:0] nib_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// rtl/nibble_serial_add_ctrl_if.sv - request/result bundle of the nibble-serial adder
interface nibble_serial_add_ctrl_if #(
  parameter int N_NIB = 4
);
  import nibble_serial_add_ctrl_pkg::*;

  localparam int W = NIB_W * N_NIB;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/nibble_serial_add_ctrl_adder4.sv
// rtl/nibble_serial_add_ctrl_adder4.sv - 4-bit ripple adder shared across nibbles
module nibble_serial_add_ctrl_adder4
  import nibble_serial_add_ctrl_pkg::*;
(
  input  nib_t a4,
  input  nib_t b4,
  input  logic ci,
  output nib_t s4,
  output logic co
);

  logic carry;

  // ripple the carry bit by bit through the nibble
  always_comb begin
    s4    = '0;
    carry = ci;
    for (int i = 0; i < NIB_W; i++) begin
      s4[i] = a4[i] ^ b4[i] ^ carry;
      carry = (a4[i] & b4[i]) | (carry & (a4[i] ^ b4[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - sequences one 4-bit adder over N_NIB nibbles, LSB first
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int N_NIB = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  nibble_serial_add_ctrl_if.slave bus
);

  localparam int W     = NIB_W * N_NIB;
  localparam int IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIB - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     acc;
  logic [W-1:0]     acc_next;
  logic [W-1:0]     sum_reg;
  logic             carry;
  logic             cout_reg;
  nib_t             a_nib;
  nib_t             b_nib;
  nib_t             s_nib;
  logic             co;

  // select the current operand nibbles and merge this cycle's result nibble
  always_comb begin
    a_nib    = a_reg[NIB_W*idx +: NIB_W];
    b_nib    = b_reg[NIB_W*idx +: NIB_W];
    acc_next = acc;
    acc_next[NIB_W*idx +: NIB_W] = s_nib;
  end

  nibble_serial_add_ctrl_adder4 u_adder4 (
    .a4 (a_nib),
    .b4 (b_nib),
    .ci (carry),
    .s4 (s_nib),
    .co (co)
  );

  // control FSM plus operand, carry, accumulator and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
            carry <= bus.cin;
            idx   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          carry <= co;
          idx   <= idx + 1'b1;
          // the final nibble lands in sum directly via acc_next
          if (idx == LAST_IDX) begin
            sum_reg  <= acc_next;
            cout_reg <= co;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (state == S_RUN) || (state == S_DONE);
  assign bus.done = (state == S_DONE);
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - scoreboard bench for the nibble-serial adder
module tb_nibble_serial_add_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t q[$];
  logic [W-1:0] held_sum;
  logic         held_cout;

  nibble_serial_add_ctrl_if #(.N_NIB(N)) bus ();

  nibble_serial_add_ctrl #(.N_NIB(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // monitor: pops on every done, otherwise the result must hold
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      held_sum  = '0;
      held_cout = 1'b0;
    end else if (bus.done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("sum", 32'(bus.sum), 32'(e.sum));
        chk("cout", 32'(bus.cout), 32'(e.cout));
        chk("done_cycle", cyc, e.due);
        held_sum  = e.sum;
        held_cout = e.cout;
      end
    end else begin
      chk("sum_hold", 32'(bus.sum), 32'(held_sum));
      chk("cout_hold", 32'(bus.cout), 32'(held_cout));
    end
  end

  // one accepted operation; junk: 0 quiet, 1 AAAA+5555 start during busy, 2 random start during busy
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc, input int junk);
    logic [W:0] r;
    exp_t e;
    r = {1'b0, ta} + {1'b0, tb_v} + (W+1)'(tc);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    bus.cin   = tc;
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.due  = cyc + 1 + N;
    q.push_back(e);
    @(posedge clk); #1;
    for (int j = 0; j <= N; j++) begin
      chk("busy_active", 32'(bus.busy), 32'd1);
      if (junk == 0) begin
        bus.start = 1'b0;
      end else if (junk == 1) begin
        bus.start = 1'b1;
        bus.a     = 16'hAAAA;
        bus.b     = 16'h5555;
        bus.cin   = 1'b1;
      end else begin
        bus.start = 1'($urandom_range(0, 1));
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("busy_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected simulation end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   gap;
    checks    = 0;
    errors    = 0;
    held_sum  = '0;
    held_cout = 1'b0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_sum", 32'(bus.sum), 32'd0);
    chk("reset_cout", 32'(bus.cout), 32'd0);

    op(16'h1234, 16'h4321, 1'b0, 0);
    op(16'hFFFF, 16'h0001, 1'b0, 0);
    op(16'hFFFF, 16'hFFFF, 1'b1, 0);
    op(16'h0001, 16'h0001, 1'b0, 1);
    repeat (3) @(posedge clk);
    #1;

    // reset two edges after acceptance aborts the operation
    bus.start = 1'b1;
    bus.a     = 16'h8000;
    bus.b     = 16'h8000;
    bus.cin   = 1'b0;
    e.sum  = 16'h0000;
    e.cout = 1'b1;
    e.due  = cyc + 1 + N;
    q.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_sum", 32'(bus.sum), 32'd0);
    chk("abort_cout", 32'(bus.cout), 32'd0);
    repeat (8) @(posedge clk);
    #1;

    // start held high: accepts at E and E+6
    bus.start = 1'b1;
    bus.a     = 16'h0F0F;
    bus.b     = 16'h00F1;
    bus.cin   = 1'b0;
    e.sum  = 16'h1000;
    e.cout = 1'b0;
    e.due  = cyc + 1 + N;
    q.push_back(e);
    @(posedge clk); #1;
    bus.a  = 16'h7FFF;
    bus.b  = 16'h0001;
    e.sum  = 16'h8000;
    e.cout = 1'b0;
    e.due  = cyc + 6 + N;
    q.push_back(e);
    repeat (6) @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (N + 1) @(posedge clk);
    #1;

    for (int i = 0; i < 1000; i++) begin
      op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 2);
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      #1;
    end

    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", q.size(), 32'd0);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter N_NIB, default 4: number of 4-bit nibbles per operand; operand width W = 4*N_NIB.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request to add a, b, cin; sampled only in IDLE.
REQ-005 a  input  W  operand A; captured on the accepting edge.
REQ-006 b  input  W  operand B; captured on the accepting edge.
REQ-007 cin  input  1  carry-in; captured on the accepting edge.
REQ-008 busy  output  1  high in RUN and DONE.
REQ-009 done  output  1  one-cycle pulse; sum and cout are valid and new while high.
REQ-010 sum  output  W  registered result; holds its value until the next completion.
REQ-011 cout  output  1  registered carry-out of the top nibble; holds like sum.

Function
REQ-012 The block sequences one shared 4-bit ripple-adder datapath (a4, b4, ci -> s4, co) over N_NIB cycles, least-significant nibble first.
REQ-013 FSM states: IDLE, RUN, DONE; encoding 2 bits.
REQ-014 IDLE: if start=1 at the edge, capture a, b into operand registers, cin into the carry register, set nibble index idx=0, and go to RUN; otherwise stay in IDLE.
REQ-015 RUN: the datapath sees a_reg[4*idx+:4], b_reg[4*idx+:4], and the carry register; each edge writes s4 into accumulator nibble idx, loads co into the carry register, and increments idx.
REQ-016 RUN exit: on the edge where idx==N_NIB-1, copy the completed accumulator to sum, copy co to cout, and go to DONE.
REQ-017 DONE: done=1 for exactly one cycle; the next edge returns to IDLE unconditionally.
REQ-018 Latency: with start sampled at edge E, done is high between edge E+N_NIB and edge E+N_NIB+1.
REQ-019 Throughput: the earliest next acceptance is edge E+N_NIB+2, so one operation per N_NIB+2 cycles.
REQ-020 Width: idx is clog2(N_NIB) bits, minimum 1; carries propagate only through the carry register.
REQ-021 start while busy, including the DONE cycle, is ignored and not queued.
REQ-022 Input changes after acceptance do not affect the result in progress.
REQ-023 sum and cout do not change during RUN; they change only on the RUN to DONE edge.
REQ-024 Start held high continuously starts a new operation on every IDLE cycle and uses the operands present at each accepting edge.

Reset
REQ-025 When rst_n=0 at an edge: state=IDLE; idx, operand registers, carry register, accumulator, sum, and cout are set to 0; busy=0; done=0.
REQ-026 Reset has priority over all transitions.
REQ-027 Reset mid-RUN or mid-DONE aborts the operation: no done pulse, and sum reads 0.

Structure
REQ-028 A shared package holds the FSM state constants (IDLE=0, RUN=1, DONE=2) and the nibble width constant NIB_W=4.
REQ-029 One sub-module, adder4: a 4-bit ripple adder (a4, b4, ci -> s4, co), instantiated once. All sequencing lives in nibble_serial_add_ctrl.

Verification
REQ-030 Basic add: a=0x1234, b=0x4321, cin=0, start pulsed at edge E -> done at E+4, sum=0x5555, cout=0, busy high for 5 cycles.
REQ-031 Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Then a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
REQ-032 Start while busy: accept a=0x0001, b=0x0001, then drive start=1 with a=0xAAAA, b=0x5555 during RUN and DONE -> one done only, sum=0x0002; the second operation starts only after the first returns to IDLE.
REQ-033 Reset mid-operation: rst_n=0 at E+2 after accepting a=0x8000, b=0x8000 -> IDLE, busy=0, no done, sum=0x0000, cout=0.
REQ-034 Back-to-back: start held high, first operands 0x0F0F+0x00F1, second 0x7FFF+0x0001 -> done pulses at E+4 (sum=0x1000) and E+10 (sum=0x8000, cout=0).
REQ-035 Random: 1000 random a, b, cin with random start gaps -> every done matches the reference sum of a+b+cin, and sum holds stable between done pulses.
